// File: rtl/parity_pkg.sv
// Shared types and defaults for the even-parity path stages.
// Reused by the frame receiver, parity generator and checker.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } pfr_state_t;

    localparam int DATA_BITS = 4;
    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/parity_frame_receiver_if.sv
// Serial-in / parallel-out bundle of the parity frame receiver.
// master drives the serial line, slave is the receiver.
interface parity_frame_receiver_if #(
    parameter int DATA_BITS = parity_pkg::DATA_BITS,
    parameter int ERR_CNT_W = parity_pkg::ERR_CNT_W
);
    logic                 bit_tick;
    logic                 serial_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 parity_out;
    logic                 frame_valid;
    logic                 parity_err;
    logic                 framing_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output bit_tick, serial_in,
        input  data_out, parity_out, frame_valid,
        input  parity_err, framing_err, err_count
    );

    modport slave (
        input  bit_tick, serial_in,
        output data_out, parity_out, frame_valid,
        output parity_err, framing_err, err_count
    );
endinterface

// File: rtl/pfr_shift_reg.sv
// MSB-first serial-to-parallel shift register for the frame receiver.
// Shifts din into bit 0 on en; the first bit ends up at the MSB.
module pfr_shift_reg #(
    parameter int DATA_BITS = parity_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 din,
    output logic [DATA_BITS-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= {q[DATA_BITS-2:0], din};
        end
    end

endmodule

// File: rtl/parity_frame_receiver.sv
// Frames start/data/parity/stop bits sampled on bit_tick into a nibble.
// Optional saturating error counter enabled by PFR_ERROR_COUNT_EN.
module parity_frame_receiver #(
    parameter int DATA_BITS = parity_pkg::DATA_BITS,
    parameter int ERR_CNT_W = parity_pkg::ERR_CNT_W
) (
    input logic                    clk,
    input logic                    rst,
    parity_frame_receiver_if.slave bus
);
    import parity_pkg::*;

    localparam int CW = $clog2(DATA_BITS + 1);

    pfr_state_t           state_q;
    pfr_state_t           state_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic                 shift_en;
    logic                 par_ld;
    logic                 done;
    logic [DATA_BITS-1:0] sr_q;
    logic                 par_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 pout_q;
    logic                 fv_q;
    logic                 perr_q;
    logic                 ferr_q;

    pfr_shift_reg #(
        .DATA_BITS(DATA_BITS)
    ) u_sr (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .din (bus.serial_in),
        .q   (sr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        par_ld   = 1'b0;
        done     = 1'b0;
        if (bus.bit_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.serial_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_ld  = 1'b1;
                    state_d = STOP;
                end
                STOP: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Results are latched on the stop tick and held until the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q  <= 1'b0;
            data_q <= '0;
            pout_q <= 1'b0;
            fv_q   <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            fv_q <= done;
            if (par_ld) begin
                par_q <= bus.serial_in;
            end
            if (done) begin
                data_q <= sr_q;
                pout_q <= par_q;
                perr_q <= ^{sr_q, par_q};
                ferr_q <= ~bus.serial_in;
            end
        end
    end

    assign bus.data_out    = data_q;
    assign bus.parity_out  = pout_q;
    assign bus.frame_valid = fv_q;
    assign bus.parity_err  = perr_q;
    assign bus.framing_err = ferr_q;

`ifdef PFR_ERROR_COUNT_EN
    logic [ERR_CNT_W-1:0] ec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ec_q <= '0;
        end else if (fv_q && (perr_q || ferr_q) && (ec_q != '1)) begin
            ec_q <= ec_q + 1'b1;
        end
    end

    assign bus.err_count = ec_q;
`else
    assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Scoreboard bench for parity_frame_receiver (ERR_CNT_W=2).
// Expected frames are queued when driven and checked on frame_valid.
module tb_parity_frame_receiver;

    localparam int DW = 4;
    localparam int EW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    parity_frame_receiver_if #(.DATA_BITS(DW), .ERR_CNT_W(EW)) bus ();

    parity_frame_receiver #(
        .DATA_BITS(DW),
        .ERR_CNT_W(EW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          p;
        logic          pe;
        logic          fe;
        int            ec;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   pend = 1'b0;
    int   ec_m = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pend) begin
            chk("fv_one_cycle", int'(bus.frame_valid), 0);
            chk("err_count", int'(bus.err_count), cur.ec);
            pend = 1'b0;
        end
        if (bus.frame_valid) begin
            if (q.size() == 0) begin
                chk("spurious_fv", int'(bus.frame_valid), 0);
            end else begin
                cur = q.pop_front();
                chk("data_out", int'(bus.data_out), int'(cur.d));
                chk("parity_out", int'(bus.parity_out), int'(cur.p));
                chk("parity_err", int'(bus.parity_err), int'(cur.pe));
                chk("framing_err", int'(bus.framing_err), int'(cur.fe));
                pend = 1'b1;
            end
        end
    end

    task automatic tick_bit(input logic b);
        bus.serial_in = b;
        bus.bit_tick  = 1'b1;
        @(negedge clk);
        bus.bit_tick  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p,
                              input logic stop);
        exp_t e;
        logic err;
        e.d  = d;
        e.p  = p;
        e.pe = ^{d, p};
        e.fe = ~stop;
        err  = e.pe | e.fe;
`ifdef PFR_ERROR_COUNT_EN
        if (err && ec_m < 3) ec_m++;
`else
        ec_m = 0;
`endif
        e.ec = ec_m;
        q.push_back(e);
        tick_bit(1'b0);
        for (int i = DW - 1; i >= 0; i--) tick_bit(d[i]);
        tick_bit(p);
        tick_bit(stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick_bit(1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() != 0 || pend); i++) begin
            @(negedge clk);
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, int'(bus.data_out), 0);
        chk({tag, "_par"}, int'(bus.parity_out), 0);
        chk({tag, "_fv"}, int'(bus.frame_valid), 0);
        chk({tag, "_perr"}, int'(bus.parity_err), 0);
        chk({tag, "_ferr"}, int'(bus.framing_err), 0);
        chk({tag, "_ec"}, int'(bus.err_count), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.bit_tick = 1'b0;
        @(negedge clk);
        chk_zero("rst");
        @(negedge clk);
        rst  = 1'b0;
        ec_m = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.bit_tick  = 1'b0;
        bus.serial_in = 1'b1;
        @(negedge clk);
        do_reset();
        idle(2);

        send_frame(4'b1011, 1'b1, 1'b1);
        drain();

        tick_bit(1'b0);
        tick_bit(1'b1);
        tick_bit(1'b1);
        do_reset();
        idle(1);
        send_frame(4'b0101, 1'b0, 1'b1);
        drain();

        send_frame(4'b1011, 1'b0, 1'b1);
        idle(1);
        send_frame(4'b0000, 1'b0, 1'b0);
        idle(2);
        drain();

        send_frame(4'b0110, 1'b0, 1'b1);
        send_frame(4'b1111, 1'b0, 1'b1);
        idle(1);
        drain();

        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_frame(4'b1011, 1'b0, 1'b1);
        end
        idle(1);
        drain();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
